// File: rtl/tick_button_debounce_clk_divider.sv
// Free-running power-of-two divider: a 50 % duty slow level plus a one-cycle
// tick on the first clk of each slow high phase.
module clk_divider #(
    parameter int PWR_2 = 20
) (
    input  logic clk,
    input  logic reset,
    output logic sclk,
    output logic sclk_tick
);

    localparam logic [PWR_2-1:0] HALF = {1'b1, {(PWR_2-1){1'b0}}};

    logic [PWR_2-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) count <= '0;
        else       count <= count + PWR_2'(1);
    end

    // Both outputs decode a flop directly, so a reset edge clears them too.
    assign sclk      = count[PWR_2-1];
    assign sclk_tick = (count == HALF);

endmodule

// File: rtl/tick_button_debounce.sv
// Button front end: two-flop synchroniser, tick-sampled debounce window and
// press/release strobes, all on clk. The release strobe is called
// "released" because "release" is a reserved word in SystemVerilog.
module tick_button_debounce #(
    parameter int PWR_2    = 20,
    parameter int STABLE_N = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic i,
    output logic sclk,
    output logic sclk_tick,
    output logic o,
    output logic press,
    output logic released
);

    logic [1:0]          sync;
    logic                synced;
    logic [STABLE_N-1:0] window;
    logic [STABLE_N-1:0] window_next;
    logic                o_prev;

    clk_divider #(.PWR_2(PWR_2)) u_clk_divider (
        .clk       (clk),
        .reset     (reset),
        .sclk      (sclk),
        .sclk_tick (sclk_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) sync <= '0;
        else       sync <= {sync[0], i};
    end

    assign synced = sync[1];

    // The level decision looks at the window including the bit shifted in on
    // this same tick; the size cast keeps this legal for STABLE_N = 1.
    assign window_next = STABLE_N'({window, synced});

    always_ff @(posedge clk) begin
        if (reset) begin
            window <= '0;
            o      <= 1'b0;
        end else if (sclk_tick) begin
            window <= window_next;
            if (&window_next)      o <= 1'b1;
            else if (~|window_next) o <= 1'b0;
        end
    end

    // Clearing o_prev together with o means a reset never looks like a release.
    always_ff @(posedge clk) begin
        if (reset) o_prev <= 1'b0;
        else       o_prev <= o;
    end

    assign press    = o & ~o_prev;
    assign released = ~o & o_prev;

endmodule

// File: tb/tb_tick_button_debounce.sv
// Directed bench for tick_button_debounce at PWR_2=4, STABLE_N=3: a
// cycle-count/sample-history model checked every cycle plus literal pins.
module tb_tick_button_debounce;

    localparam int PWR_2    = 4;
    localparam int STABLE_N = 3;
    localparam int PERIOD   = 1 << PWR_2;
    localparam int HALF     = PERIOD / 2;

    logic clk = 1'b0;
    logic reset;
    logic i;
    logic sclk, sclk_tick, o, press, released;

    int n_cmp = 0;
    int n_bad = 0;
    int tc    = 0;
    int press_count = 0;
    int rel_count   = 0;

    tick_button_debounce #(.PWR_2(PWR_2), .STABLE_N(STABLE_N)) dut (
        .clk       (clk),
        .reset     (reset),
        .i         (i),
        .sclk      (sclk),
        .sclk_tick (sclk_tick),
        .o         (o),
        .press     (press),
        .released  (released)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @tc=%0d: got %0h expected %0h", name, tc, act, exp);
        end
    endtask

    // Model: cycles since reset, raw input history, and the list of tick samples.
    bit   m_valid = 1'b0;
    int   m_cyc;
    bit   ihist[$];
    bit   samples[$];
    bit   m_o, m_oprev, m_s, m_ones, m_zeros;

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b1;
            m_cyc   = 0;
            ihist.delete();
            samples.delete();
            for (int k = 0; k < STABLE_N; k++) samples.push_back(1'b0);
            m_o     = 1'b0;
            m_oprev = 1'b0;
        end else if (m_valid) begin
            m_oprev = m_o;
            ihist.push_back(i);
            if (m_cyc % PERIOD == HALF) begin
                m_s = (m_cyc >= 2) ? ihist[m_cyc-2] : 1'b0;
                samples.push_back(m_s);
                m_ones  = 1'b1;
                m_zeros = 1'b1;
                for (int k = samples.size() - STABLE_N; k < samples.size(); k++) begin
                    if (samples[k]) m_zeros = 1'b0;
                    else            m_ones  = 1'b0;
                end
                if (m_ones)  m_o = 1'b1;
                if (m_zeros) m_o = 1'b0;
            end
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("sclk",      sclk,      (m_cyc % PERIOD) >= HALF);
            check("sclk_tick", sclk_tick, (m_cyc % PERIOD) == HALF);
            check("o",         o,         m_o);
            check("press",     press,     m_o & ~m_oprev);
            check("released",  released,  ~m_o & m_oprev);
            check("strobe_excl", press & released, 1'b0);
            if (press === 1'b1)    press_count++;
            if (released === 1'b1) rel_count++;
        end
    end

    task automatic next_cycle();
        @(negedge clk);
        tc++;
    endtask

    task automatic run_until(input int t);
        while (tc < t) next_cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tc = 0;
    endtask

    initial begin
        reset = 1'b1;
        i     = 1'b0;

        // Divider and clean press
        do_reset();
        check("lit_rst_sclk", sclk, 1'b0);
        check("lit_rst_o", o, 1'b0);
        run_until(2);  i = 1'b1;
        run_until(7);  check("lit_sclk_c7", sclk, 1'b0); check("lit_tick_c7", sclk_tick, 1'b0);
        run_until(8);  check("lit_sclk_c8", sclk, 1'b1); check("lit_tick_c8", sclk_tick, 1'b1);
        run_until(9);  check("lit_tick_c9", sclk_tick, 1'b0);
        run_until(16); check("lit_sclk_c16", sclk, 1'b0);
        run_until(24); check("lit_tick_c24", sclk_tick, 1'b1);
        run_until(40); check("lit_o_c40", o, 1'b0); check("lit_tick_c40", sclk_tick, 1'b1);
        run_until(41); check("lit_o_c41", o, 1'b1); check("lit_press_c41", press, 1'b1);
        check("model_o_c41", m_o, 1'b1);
        run_until(42); check("lit_press_c42", press, 1'b0);

        // Release from o=1
        run_until(45); i = 1'b0;
        run_until(88); check("lit_o_c88", o, 1'b1);
        run_until(89); check("lit_o_c89", o, 1'b0); check("lit_rel_c89", released, 1'b1);
        check("lit_press_c89", press, 1'b0);
        run_until(90); check("lit_rel_c90", released, 1'b0);

        // Glitch spanning only two ticks
        do_reset();
        press_count = 0;
        run_until(6);  i = 1'b1;
        run_until(26); i = 1'b0;
        run_until(100);
        check("lit_glitch_o", o, 1'b0);
        check("lit_glitch_press", press_count, 0);

        // Bounce every 5 cycles, then hold high
        do_reset();
        press_count = 0;
        while (tc < 200) begin
            i = ((tc / 5) % 2 == 0);
            next_cycle();
        end
        i = 1'b1;
        run_until(248); check("lit_bounce_o_c248", o, 1'b0);
        run_until(249); check("lit_bounce_o_c249", o, 1'b1); check("lit_bounce_press", press, 1'b1);
        run_until(260); check("lit_bounce_count", press_count, 1);

        // Mid-operation reset with o=1 and the button still held
        rel_count = 0;
        do_reset();
        check("lit_mid_sclk", sclk, 1'b0);
        check("lit_mid_tick", sclk_tick, 1'b0);
        check("lit_mid_o", o, 1'b0);
        check("lit_mid_rel", released, 1'b0);
        run_until(5);  check("lit_mid_rel_count", rel_count, 0);
        run_until(40); check("lit_mid_o_c40", o, 1'b0);
        run_until(41); check("lit_mid_o_c41", o, 1'b1);
        run_until(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
